// File: rtl/popcount_tree_pipe.sv
// Pipelined population count built from 5:3 compressors, with an optional
// saturating multi-beat accumulator and valid/ready handshakes on both sides.
module popcount_tree_pipe #(
  parameter int N     = 17,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_count,
  output logic             out_last,
  output logic             out_sat
);

  localparam int CW = $clog2(N + 1);
  localparam int NG = (N + 3) / 4;
  localparam int NP = NG * 4;
  localparam int AW = ACC_W + 1;

  // Count of five bits as a 3-bit value: two full adders feed a half adder on weight 2.
  function automatic logic [2:0] compress_5_3(input logic [3:0] bits, input logic cin);
    logic s1, c1, s0, c2;
    s1 = bits[0] ^ bits[1] ^ bits[2];
    c1 = (bits[0] & bits[1]) | (bits[0] & bits[2]) | (bits[1] & bits[2]);
    s0 = s1 ^ bits[3] ^ cin;
    c2 = (s1 & bits[3]) | (s1 & cin) | (bits[3] & cin);
    return {c1 & c2, c1 ^ c2, s0};
  endfunction

  // Returns {clamped_flag, value}; acc never exceeds 2^ACC_W-1, so bit ACC_W of the raw sum is the overflow.
  function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] acc, input logic [CW-1:0] pc);
    logic [AW-1:0] sum;
    sum = acc + AW'(pc);
    if (sum[ACC_W]) return {1'b1, {ACC_W{1'b1}}};
    return {1'b0, sum[ACC_W-1:0]};
  endfunction

  logic stall;

  logic             vld_p0_q, vld_p0_d;
  logic [N-1:0]     data_p0_q, data_p0_d;
  logic             mode_p0_q, mode_p0_d;
  logic             last_p0_q, last_p0_d;

  logic             vld_p1_q, vld_p1_d;
  logic [3*NG-1:0]  part_p1_q, part_p1_d;
  logic             mode_p1_q, mode_p1_d;
  logic             last_p1_q, last_p1_d;

  logic             vld_p2_q, vld_p2_d;
  logic [CW-1:0]    pc_p2_q, pc_p2_d;
  logic             mode_p2_q, mode_p2_d;
  logic             last_p2_q, last_p2_d;

  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_count_q, out_count_d;
  logic             out_last_q, out_last_d;
  logic             out_sat_q, out_sat_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic             sticky_q, sticky_d;

  logic [NP-1:0]    padded;
  logic [CW-1:0]    pc_sum;
  logic [AW-1:0]    sat_res;

  assign stall     = out_valid_q && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign out_last  = out_last_q;
  assign out_sat   = out_sat_q;

  // Stage p0: input capture
  always_comb begin
    vld_p0_d  = vld_p0_q;
    data_p0_d = data_p0_q;
    mode_p0_d = mode_p0_q;
    last_p0_d = last_p0_q;
    if (!stall) begin
      vld_p0_d  = in_valid;
      data_p0_d = in_data;
      mode_p0_d = in_mode;
      last_p0_d = in_last;
    end
  end

  // Stage p1: per-nibble 5:3 compression, carry-in tied low
  always_comb begin
    padded         = '0;
    padded[N-1:0]  = data_p0_q;
    vld_p1_d       = vld_p1_q;
    part_p1_d      = part_p1_q;
    mode_p1_d      = mode_p1_q;
    last_p1_d      = last_p1_q;
    if (!stall) begin
      vld_p1_d  = vld_p0_q;
      mode_p1_d = mode_p0_q;
      last_p1_d = last_p0_q;
      for (int g = 0; g < NG; g++) begin
        part_p1_d[3*g +: 3] = compress_5_3(padded[4*g +: 4], 1'b0);
      end
    end
  end

  // Stage p2: sum of partial counts
  always_comb begin
    pc_sum = '0;
    for (int g = 0; g < NG; g++) begin
      pc_sum = pc_sum + CW'(part_p1_q[3*g +: 3]);
    end
    vld_p2_d  = vld_p2_q;
    pc_p2_d   = pc_p2_q;
    mode_p2_d = mode_p2_q;
    last_p2_d = last_p2_q;
    if (!stall) begin
      vld_p2_d  = vld_p1_q;
      pc_p2_d   = pc_sum;
      mode_p2_d = mode_p1_q;
      last_p2_d = last_p1_q;
    end
  end

  // Output stage: per-beat result or saturating accumulation
  always_comb begin
    sat_res     = sat_add(acc_q, pc_p2_q);
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    out_last_d  = out_last_q;
    out_sat_d   = out_sat_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    if (!stall) begin
      out_valid_d = vld_p2_q && (!mode_p2_q || last_p2_q);
      if (vld_p2_q) begin
        if (!mode_p2_q) begin
          out_count_d = ACC_W'(pc_p2_q);
          out_last_d  = last_p2_q;
          out_sat_d   = 1'b0;
        end else if (last_p2_q) begin
          out_count_d = sat_res[ACC_W-1:0];
          out_last_d  = 1'b1;
          out_sat_d   = sticky_q | sat_res[ACC_W];
          acc_d       = '0;
          sticky_d    = 1'b0;
        end else begin
          acc_d    = {1'b0, sat_res[ACC_W-1:0]};
          sticky_d = sticky_q | sat_res[ACC_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      vld_p0_q    <= vld_p0_d;
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_last_q  <= out_last_d;
      out_sat_q   <= out_sat_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
    end
  end

  // Payload registers are qualified by the valids, so they need no reset.
  always_ff @(posedge clk) begin
    data_p0_q <= data_p0_d;
    mode_p0_q <= mode_p0_d;
    last_p0_q <= last_p0_d;
    part_p1_q <= part_p1_d;
    mode_p1_q <= mode_p1_d;
    last_p1_q <= last_p1_d;
    pc_p2_q   <= pc_p2_d;
    mode_p2_q <= mode_p2_d;
    last_p2_q <= last_p2_d;
  end

endmodule

// File: tb/tb_popcount_tree_pipe.sv
// Bench for popcount_tree_pipe: directed vector table, reset/backpressure sequences,
// and random traffic scored against a queue-based model (ACC_W=16 and ACC_W=6 instances).
module tb_popcount_tree_pipe;
  localparam int N = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic [N-1:0] in_data = '0;
  logic         in_mode = 1'b0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b1;

  logic         in_ready_a, out_valid_a, out_last_a, out_sat_a;
  logic [15:0]  out_count_a;
  logic         in_ready_b, out_valid_b, out_last_b, out_sat_b;
  logic [5:0]   out_count_b;

  popcount_tree_pipe #(.N(N), .ACC_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_count(out_count_a),
    .out_last(out_last_a), .out_sat(out_sat_a));

  popcount_tree_pipe #(.N(N), .ACC_W(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_count(out_count_b),
    .out_last(out_last_b), .out_sat(out_sat_b));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct { int cnt; bit lst; bit sat; } exp_t;
  typedef struct { int ca; bit l; bit sa; int cb; bit sb; int cyc; } got_t;

  exp_t expa[$];
  exp_t expb[$];
  got_t got[$];
  int   acc_cyc[$];
  int   cyc = 0;
  int   accm[2];
  bit   stk[2];
  int   maxv[2] = '{65535, 63};
  bit   prev_stall = 1'b0;
  int   prev_count = 0;
  bit   prev_last = 1'b0;

  // Monitor: samples 1 time unit before each rising edge, i.e. what that edge will see.
  always @(negedge clk) begin : mon
    int   pc;
    int   s;
    bit   cl;
    exp_t e;
    #4;
    if (!rst_n) begin
      expa.delete();
      expb.delete();
      accm[0] = 0; accm[1] = 0;
      stk[0] = 1'b0; stk[1] = 1'b0;
      prev_stall = 1'b0;
    end else begin
      cyc++;
      if (prev_stall) begin
        check("hold_valid", longint'(out_valid_a), 1);
        check("hold_count", longint'(out_count_a), prev_count);
        check("hold_last", longint'(out_last_a), longint'(prev_last));
      end
      prev_stall = out_valid_a && !out_ready;
      prev_count = int'(out_count_a);
      prev_last  = out_last_a;
      if (out_valid_a && out_ready) begin
        got.push_back('{int'(out_count_a), out_last_a, out_sat_a, int'(out_count_b), out_sat_b, cyc});
        check("valid_b", longint'(out_valid_b), 1);
        if (expa.size() == 0 || expb.size() == 0) begin
          check("sb_unexpected_output", 1, 0);
        end else begin
          e = expa.pop_front();
          check("sb_count_a", longint'(out_count_a), e.cnt);
          check("sb_last_a", longint'(out_last_a), longint'(e.lst));
          check("sb_sat_a", longint'(out_sat_a), longint'(e.sat));
          e = expb.pop_front();
          check("sb_count_b", longint'(out_count_b), e.cnt);
          check("sb_sat_b", longint'(out_sat_b), longint'(e.sat));
        end
      end
      if (in_valid && in_ready_a) begin
        acc_cyc.push_back(cyc);
        pc = $countones(in_data);
        for (int k = 0; k < 2; k++) begin
          if (!in_mode) begin
            e = '{pc, in_last, 1'b0};
            if (k == 0) expa.push_back(e); else expb.push_back(e);
          end else begin
            s  = accm[k] + pc;
            cl = (s > maxv[k]);
            if (cl) s = maxv[k];
            if (in_last) begin
              e = '{s, 1'b1, stk[k] | cl};
              if (k == 0) expa.push_back(e); else expb.push_back(e);
              accm[k] = 0;
              stk[k]  = 1'b0;
            end else begin
              accm[k] = s;
              stk[k]  = stk[k] | cl;
            end
          end
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the beat is taken.
  task automatic send(input logic [N-1:0] d, input bit m, input bit l);
    bit ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_mode = m; in_last = l;
    for (int t = 0; t < 50 && !ok; t++) begin
      #4;
      ok = in_ready_a;
      @(negedge clk);
    end
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic wait_got(input int n);
    int t = 0;
    while (got.size() < n && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_count", got.size(), n);
  endtask

  typedef struct {
    logic [N-1:0] d; bit m; bit l; bit has;
    int ca; bit sa; int cb; bit sb;
  } vec_t;
  vec_t tv[15];

  initial begin
    int j;
    int first_cnt;

    // Reset state, asserted from time 0
    #2;
    check("rst_valid", longint'(out_valid_a), 0);
    check("rst_count", longint'(out_count_a), 0);
    check("rst_sat", longint'(out_sat_a), 0);
    check("rst_last", longint'(out_last_a), 0);
    check("rst_valid_b", longint'(out_valid_b), 0);
    #10 rst_n = 1'b1;
    #1;
    check("rst_in_ready", longint'(in_ready_a), 1);
    @(negedge clk);

    // Directed table: mode 0 values, accumulate, interleave, saturation, last passthrough
    tv[0]  = '{17'h1FFFF, 1'b0, 1'b0, 1'b1, 17, 1'b0, 17, 1'b0};
    tv[1]  = '{17'h00000, 1'b0, 1'b0, 1'b1, 0,  1'b0, 0,  1'b0};
    tv[2]  = '{17'h0A5A5, 1'b0, 1'b0, 1'b1, 8,  1'b0, 8,  1'b0};
    tv[3]  = '{17'h1FFFF, 1'b1, 1'b0, 1'b0, 0,  1'b0, 0,  1'b0};
    tv[4]  = '{17'h000FF, 1'b1, 1'b0, 1'b0, 0,  1'b0, 0,  1'b0};
    tv[5]  = '{17'h00001, 1'b1, 1'b1, 1'b1, 26, 1'b0, 26, 1'b0};
    tv[6]  = '{17'h0000F, 1'b1, 1'b0, 1'b0, 0,  1'b0, 0,  1'b0};
    tv[7]  = '{17'h00003, 1'b0, 1'b0, 1'b1, 2,  1'b0, 2,  1'b0};
    tv[8]  = '{17'h00001, 1'b1, 1'b1, 1'b1, 5,  1'b0, 5,  1'b0};
    tv[9]  = '{17'h1FFFF, 1'b1, 1'b0, 1'b0, 0,  1'b0, 0,  1'b0};
    tv[10] = '{17'h1FFFF, 1'b1, 1'b0, 1'b0, 0,  1'b0, 0,  1'b0};
    tv[11] = '{17'h1FFFF, 1'b1, 1'b0, 1'b0, 0,  1'b0, 0,  1'b0};
    tv[12] = '{17'h1FFFF, 1'b1, 1'b1, 1'b1, 68, 1'b0, 63, 1'b1};
    tv[13] = '{17'h00001, 1'b1, 1'b1, 1'b1, 1,  1'b0, 1,  1'b0};
    tv[14] = '{17'h10001, 1'b0, 1'b1, 1'b1, 2,  1'b0, 2,  1'b0};

    got.delete();
    acc_cyc.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) send(tv[i].d, tv[i].m, tv[i].l);
    in_valid = 1'b0;
    wait_got(9);
    j = 0;
    for (int i = 0; i < 15; i++) begin
      if (tv[i].has && j < got.size()) begin
        check($sformatf("tv%0d_count_a", i), got[j].ca, tv[i].ca);
        check($sformatf("tv%0d_sat_a", i), longint'(got[j].sa), longint'(tv[i].sa));
        check($sformatf("tv%0d_last", i), longint'(got[j].l), longint'(tv[i].l));
        check($sformatf("tv%0d_count_b", i), got[j].cb, tv[i].cb);
        check($sformatf("tv%0d_sat_b", i), longint'(got[j].sb), longint'(tv[i].sb));
        // The handshake sample precedes the edge after the one where out_valid rose.
        check($sformatf("tv%0d_latency", i), (got[j].cyc - 1) - acc_cyc[i], 3);
        j++;
      end
    end

    // Backpressure: 5 beats of one set bit, then 4 stalled cycles
    got.delete();
    for (int i = 0; i < 5; i++) send(17'h00001, 1'b0, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #4;
      check("bp_in_ready", longint'(in_ready_a), 0);
      check("bp_valid", longint'(out_valid_a), 1);
      check("bp_count", longint'(out_count_a), 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_got(5);
    for (int i = 0; i < got.size(); i++) check("bp_result", got[i].ca, 1);

    // Asynchronous reset while results are in flight
    out_ready = 1'b0;
    send(17'h1FFFF, 1'b0, 1'b0);
    send(17'h00003, 1'b1, 1'b0);
    send(17'h00007, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_valid", longint'(out_valid_a), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", longint'(out_valid_a), 0);
    check("midrst_count", longint'(out_count_a), 0);
    check("midrst_sat", longint'(out_sat_a), 0);
    check("midrst_in_ready", longint'(in_ready_a), 1);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    got.delete();
    repeat (8) @(negedge clk);
    check("post_rst_outputs", got.size(), 0);
    check("post_rst_valid", longint'(out_valid_a), 0);
    check("post_rst_in_ready", longint'(in_ready_a), 1);
    first_cnt = 0;

    // Random traffic with random backpressure, scored by the monitor model
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = N'($urandom);
      in_mode   = $urandom_range(0, 1) != 0;
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(17'h00000, 1'b1, 1'b1);
    in_valid = 1'b0;
    while ((expa.size() != 0 || expb.size() != 0) && first_cnt < 100) begin
      @(negedge clk);
      first_cnt++;
    end
    check("rand_drain_a", expa.size(), 0);
    check("rand_drain_b", expb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/popcount_tree_pipe.md
# popcount_tree_pipe

Pipelined, parametrised population-count unit built from 5:3 compressor reduction. It counts the ones in an N-bit input vector each beat and either returns the per-beat count or accumulates counts over a multi-beat group, with saturation. It sits between bit-vector producers (match masks, syndrome vectors) and downstream counters. Valid/ready handshakes sit on both sides.

## Interface
- N, 17, input vector width; legal range 2..64
- ACC_W, 16, output/accumulator width; must be at least CW = clog2(N+1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  unit can accept a beat this cycle
- in_data  input  N  vector to count
- in_mode  input  1  0 = per-beat count, 1 = accumulate until in_last
- in_last  input  1  marks final beat of an accumulate group; passed through in mode 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_count  output  ACC_W  count or accumulated sum, zero-extended
- out_last  output  1  copy of the in_last of the producing beat
- out_sat  output  1  accumulated sum clamped at 2^ACC_W-1

## Operation
- A beat is accepted on a rising edge with in_valid && in_ready. in_data, in_mode and in_last travel together through the pipeline.
- Stage 1 (registered): split in_data into groups of 4 bits, zero-padded to a multiple of 4. Reduce each group with a 5:3 compressor whose carry-in is tied to 0. Register the per-group 3-bit partial counts.
- Stage 2 (registered): sum the partial counts to a CW-bit popcount.
- Stage 3 (registered output plus accumulator):
  - Mode 0: out_count = popcount, out_sat = 0. The accumulator is not touched.
  - Mode 1, not last: acc = min(acc + popcount, 2^ACC_W-1). The sticky saturation flag is set if a clamp occurs. No output is produced.
  - Mode 1, last: out_count = min(acc + popcount, max), out_sat = sticky flag OR clamp-now. acc and the sticky flag clear to 0 in the same cycle.
- Mode 0 beats may be interleaved inside an open accumulate group. They do not disturb it.
- Arithmetic is unsigned. The accumulator is ACC_W+1 bits internally so overflow can be detected before clamping.
- Reset (asynchronous, any time, including mid-group):
  - All stage valids, out_valid, out_count, out_last and out_sat go to 0.
  - acc and the sticky flag go to 0.
  - In-flight beats are discarded.
  - in_ready = 1 once rst_n is high.

## Timing
- Latency: a beat accepted at edge k drives out_valid=1 after edge k+3, with no stall. Mode-1 non-last beats update acc at edge k+3 and produce no output.
- Throughput: 1 beat/cycle.
- Global stall: stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stalled, all stage registers and acc hold, and out_count, out_last and out_sat are stable.
  - Bubbles are not squeezed out during a stall.
- out_valid deasserts on the edge where out_ready=1 unless a new result is arriving in the same cycle.
- The result is held until handshaken. No result is dropped or duplicated.
- When in_valid=0 at acceptance, a bubble propagates and no output appears for it.
- A simultaneous output handshake and input acceptance in one cycle is legal and required for full throughput.

## Test plan
- Reset mid-stream (N=17, ACC_W=16): drive 3 beats, pull rst_n low asynchronously between edges. Required: out_valid, out_count and out_sat drop to 0 immediately, no stale output after release, and in_ready=1.
- Mode 0 values: in_data = 17'h1FFFF, 17'h00000, 17'h0A5A5 on consecutive cycles, out_ready=1. Required: out_count = 17, 0, 8 on cycles k+3, k+4, k+5, with out_sat=0.
- Backpressure: 5 back-to-back mode 0 beats of 17'h00001, then hold out_ready=0 for 4 cycles. Required: in_ready=0, out_count held at 1, and all 5 results delivered in order after release with none lost.
- Accumulate group: mode-1 beats 17'h1FFFF, 17'h000FF, 17'h00001 (last on the third). Required: a single output of 26 with out_last=1 and out_sat=0, and acc=0 afterward.
- Interleave: mode-1 beat 17'h0000F, then mode 0 beat 17'h00003, then mode-1 last 17'h00001. Required: outputs 2 (mode 0), then 5.
- Saturation (ACC_W=6): four mode-1 beats of 17'h1FFFF, the last flagged. Required: out_count=63 and out_sat=1. A following group of one last beat 17'h00001 must output 1 with out_sat=0.
